game_controller: RTL and testbench



---
 rtl/game_controller.sv | 155 +++++++++++++++
 tb/tb_game_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Game sequencer for the scrolling-bar game. It runs the idle/play/pause/level-up/game-over
// state machine, paces the environment with env_tick and keeps the score and level.
module game_controller #(
    parameter int TICK_DIV         = 5_000_000,
    parameter int PASSES_PER_LEVEL = 8,
    parameter int LEVEL_UP_CYCLES  = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       collision,
    input  logic       bar_passed,
    output logic       env_tick,
    output logic       pause,
    output logic [9:0] level,
    output logic [9:0] score,
    output logic       game_over,
    output logic [2:0] state
);

    // state       | meaning
    // ST_IDLE      | waiting for start; score/level of the last game still shown
    // ST_PLAY      | game running, tick counter paces the environment
    // ST_PAUSED    | frozen by the player, tick counter holds its value
    // ST_LEVEL_UP  | banner hold after a level advance
    // ST_GAME_OVER | player hit a bar; score and level frozen

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (LEVEL_UP_CYCLES > 1) ? $clog2(LEVEL_UP_CYCLES) : 1;
    localparam int PW = (PASSES_PER_LEVEL > 1) ? $clog2(PASSES_PER_LEVEL) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LEVEL_UP_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(PASSES_PER_LEVEL - 1);
    localparam logic [9:0]    CNT_MAX   = 10'd1023;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_PAUSED    = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_d;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_d;
    logic [PW-1:0] pass_cnt;
    logic [PW-1:0] pass_d;
    logic [9:0]    score_d;
    logic [9:0]    level_d;
    logic          tick_wrap;

    assign tick_wrap = (tick_cnt == TICK_LAST);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_cnt;
        hold_d  = hold_cnt;
        pass_d  = pass_cnt;
        score_d = score;
        level_d = level;
        case (state_q)
            ST_IDLE: begin
                if (start_btn) begin
                    state_d = ST_PLAY;
                    level_d = 10'd1;
                    score_d = 10'd0;
                    pass_d  = '0;
                    tick_d  = '0;
                end
            end
            ST_PLAY: begin
                tick_d = tick_wrap ? '0 : tick_cnt + TW'(1);
                // collision outranks a pass, a pass outranks pause
                if (collision) begin
                    state_d = ST_GAME_OVER;
                end else if (bar_passed) begin
                    if (score != CNT_MAX) begin
                        score_d = score + 10'd1;
                    end
                    if (pass_cnt == PASS_LAST) begin
                        pass_d  = '0;
                        hold_d  = '0;
                        state_d = ST_LEVEL_UP;
                        if (level != CNT_MAX) begin
                            level_d = level + 10'd1;
                        end
                    end else begin
                        pass_d = pass_cnt + PW'(1);
                        if (pause_btn) begin
                            state_d = ST_PAUSED;
                        end
                    end
                end else if (pause_btn) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_btn) begin
                    state_d = ST_PLAY;
                end
            end
            ST_LEVEL_UP: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d = ST_PLAY;
                    tick_d  = '0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_cnt + HW'(1);
                end
            end
            ST_GAME_OVER: begin
                if (start_btn) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // env_tick decodes the current state, so a tick still fires on the cycle PLAY is left
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
            pass_cnt  <= '0;
            score     <= 10'd0;
            level     <= 10'd1;
            env_tick  <= 1'b0;
            pause     <= 1'b1;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_cnt  <= tick_d;
            hold_cnt  <= hold_d;
            pass_cnt  <= pass_d;
            score     <= score_d;
            level     <= level_d;
            env_tick  <= (state_q == ST_PLAY) && tick_wrap;
            pause     <= (state_d != ST_PLAY);
            game_over <= (state_d == ST_GAME_OVER);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: hand-derived vector table applied through an
// expected-value queue, plus a level-climb and mid-banner reset sequence.
module tb_game_controller;

    logic       clk;
    logic       rst;
    logic       start_btn;
    logic       pause_btn;
    logic       collision;
    logic       bar_passed;
    logic       env_tick;
    logic       pause;
    logic [9:0] level;
    logic [9:0] score;
    logic       game_over;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r;
        logic       st;
        logic       pb;
        logic       co;
        logic       bp;
        logic [2:0] e_state;
        logic [9:0] e_score;
        logic [9:0] e_level;
        logic       e_tick;
    } vec_t;

    vec_t table_q[$];
    vec_t exp_q[$];

    game_controller #(
        .TICK_DIV(4),
        .PASSES_PER_LEVEL(2),
        .LEVEL_UP_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_btn(start_btn),
        .pause_btn(pause_btn),
        .collision(collision),
        .bar_passed(bar_passed),
        .env_tick(env_tick),
        .pause(pause),
        .level(level),
        .score(score),
        .game_over(game_over),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic st, logic pb, logic co, logic bp,
                                logic [2:0] es, int sc, int lv, logic tk);
        vec_t v;
        v.r = r; v.st = st; v.pb = pb; v.co = co; v.bp = bp;
        v.e_state = es; v.e_score = 10'(sc); v.e_level = 10'(lv); v.e_tick = tk;
        return v;
    endfunction

    function automatic void add(logic st, logic pb, logic co, logic bp,
                                logic [2:0] es, int sc, int lv, logic tk);
        table_q.push_back(mk(1'b0, st, pb, co, bp, es, sc, lv, tk));
    endfunction

    task automatic cmp(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // drive one cycle of inputs, queue its expectation, compare after the consuming edge
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        exp_q.push_back(v);
        rst = v.r; start_btn = v.st; pause_btn = v.pb; collision = v.co; bar_passed = v.bp;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        cmp("state", idx, int'(state), int'(e.e_state));
        cmp("score", idx, int'(score), int'(e.e_score));
        cmp("level", idx, int'(level), int'(e.e_level));
        cmp("env_tick", idx, int'(env_tick), int'(e.e_tick));
        cmp("pause", idx, int'(pause), int'(e.e_state != 3'd1));
        cmp("game_over", idx, int'(game_over), int'(e.e_state == 3'd4));
    endtask

    initial begin
        int step;
        rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; collision = 1'b0; bar_passed = 1'b0;
        step = 0;

        // start, first tick 4 cycles after entry
        add(1,0,0,0, 1,0,1,0);
        add(0,0,0,0, 1,0,1,0);
        add(0,0,0,0, 1,0,1,0);
        add(0,0,0,0, 1,0,1,0);
        add(0,0,0,0, 1,0,1,1);
        add(0,0,0,0, 1,0,1,0);
        // two passes -> level-up; the tick coincides with leaving PLAY
        add(0,0,0,1, 1,1,1,0);
        add(0,0,0,0, 1,1,1,0);
        add(0,0,0,1, 3,2,2,1);
        add(0,0,0,0, 3,2,2,0);
        add(0,0,0,0, 3,2,2,0);
        add(0,0,0,0, 1,2,2,0);
        for (int i = 0; i < 3; i++) add(0,0,0,0, 1,2,2,0);
        add(0,0,0,0, 1,2,2,1);
        add(0,0,0,0, 1,2,2,0);
        // pause two cycles after a tick, ten silent cycles, resume
        add(0,1,0,0, 2,2,2,0);
        add(0,0,0,0, 2,2,2,0);
        add(0,0,1,0, 2,2,2,0);
        add(0,0,0,1, 2,2,2,0);
        add(1,0,0,0, 2,2,2,0);
        for (int i = 0; i < 6; i++) add(0,0,0,0, 2,2,2,0);
        add(0,1,0,0, 1,2,2,0);
        add(0,0,0,0, 1,2,2,0);
        add(0,0,0,0, 1,2,2,1);
        // pass + pause together at pass counter 0, then at pass counter 1
        add(0,1,0,1, 2,3,2,0);
        add(0,1,0,0, 1,3,2,0);
        add(0,1,0,1, 3,4,3,0);
        add(0,1,0,0, 3,4,3,0);
        add(0,0,1,0, 3,4,3,0);
        add(0,0,0,0, 1,4,3,0);
        // collision beats a pass; game over freezes, restart clears
        add(0,0,0,1, 1,5,3,0);
        add(0,0,1,1, 4,5,3,0);
        add(0,1,0,1, 4,5,3,0);
        add(1,0,0,0, 0,5,3,0);
        add(0,0,0,1, 0,5,3,0);
        add(1,0,0,0, 1,0,1,0);
        add(0,0,0,1, 1,1,1,0);
        add(0,0,1,1, 4,1,1,0);
        add(1,0,0,0, 0,1,1,0);
        add(1,0,0,0, 1,0,1,0);

        // reset has priority over a start press
        apply(mk(1,1,0,0,0, 0,0,1,0), step++);
        apply(mk(1,1,0,0,0, 0,0,1,0), step++);

        foreach (table_q[k]) apply(table_q[k], step++);

        // climb to level 5, then reset in the middle of the banner
        for (int i = 0; i < 4; i++) begin
            apply(mk(0,0,0,0,1, 1, 2*i+1, i+1, 0), step++);
            apply(mk(0,0,0,0,1, 3, 2*i+2, i+2, 0), step++);
            if (i < 3) begin
                apply(mk(0,0,0,0,0, 3, 2*i+2, i+2, 0), step++);
                apply(mk(0,0,0,0,0, 3, 2*i+2, i+2, 0), step++);
                apply(mk(0,0,0,0,0, 1, 2*i+2, i+2, 0), step++);
            end
        end
        apply(mk(0,0,0,0,0, 3,8,5,0), step++);
        apply(mk(1,1,0,0,1, 0,0,1,0), step++);
        apply(mk(0,1,0,0,0, 1,0,1,0), step++);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
